// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/ULA.
// The master is the sequencer, the slave is the datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic [3:0] ALUOp;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, Zero, mem_ready,
    output ALUOp, alu_src_a, alu_src_b, pc_source, pc_write, ir_write, mem_read,
           mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, illegal, state
  );

  modport slave (
    output opcode, funct, Zero, mem_ready,
    input  ALUOp, alu_src_a, alu_src_b, pc_source, pc_write, ir_write, mem_read,
           mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back and
// drives the datapath muxes, enables and the ULA operation code.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StExecI    = 4'd10,
    StIWb      = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpSw    = 6'h2B;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  function automatic logic r_valid(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h2A: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 4'd0;
      6'h22:   return 4'd1;
      6'h18:   return 4'd2;
      6'h1A:   return 4'd3;
      6'h24:   return 4'd4;
      6'h25:   return 4'd5;
      6'h27:   return 4'd6;
      6'h00:   return 4'd7;
      6'h02:   return 4'd8;
      6'h2A:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h0C:   return 4'd4;
      6'h0D:   return 4'd5;
      6'h0A:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] br_alu(input logic [5:0] op);
    case (op)
      6'h04:   return 4'd10;
      6'h05:   return 4'd11;
      6'h06:   return 4'd15;
      6'h07:   return 4'd12;
      6'h14:   return 4'd13;
      6'h15:   return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Next state; decode works on the live IR fields while they are being latched.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        op_d    = bus.opcode;
        funct_d = bus.funct;
        case (bus.opcode)
          OpRType:                                   state_d = r_valid(bus.funct) ? StExecR
                                                                                   : StIllegal;
          6'h23, 6'h2B:                              state_d = StMemAddr;
          6'h08, 6'h0C, 6'h0D, 6'h0A:                state_d = StExecI;
          6'h04, 6'h05, 6'h06, 6'h07, 6'h14, 6'h15:  state_d = StBranch;
          6'h02:                                     state_d = StJump;
          default:                                   state_d = StIllegal;
        endcase
      end
      StExecR:   state_d = StRWb;
      StExecI:   state_d = StIWb;
      StMemAddr: state_d = (op_q == OpSw) ? StMemWrite : StMemRead;
      StMemRead: begin
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWrite: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StRWb, StIWb, StMemWb, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StIllegal: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      op_q    <= '0;
      funct_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      count_q <= count_d;
    end
  end

  // Moore outputs from state and latched fields; FETCH/BRANCH also look at the handshake/flag.
  always_comb begin
    bus.ALUOp      = 4'd0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_source  = 2'b00;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.pc_write  = bus.mem_ready;
        bus.ir_write  = bus.mem_ready;
      end
      StDecode: bus.alu_src_b = 2'b11;
      StExecR: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOp     = r_alu(funct_q);
      end
      StRWb: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOp     = r_alu(funct_q);
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      StExecI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ALUOp     = i_alu(op_q);
      end
      StIWb: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ALUOp     = i_alu(op_q);
        bus.reg_write = 1'b1;
      end
      StMemAddr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      StMemRead: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a = 1'b1;
        bus.ALUOp     = br_alu(op_q);
        bus.pc_source = 2'b01;
        bus.pc_write  = bus.Zero;
      end
      StJump: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
      end
      StIllegal: bus.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign instr_count = count_q;

endmodule
